// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run controller slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, the halt code that denotes a passing run,
// and a small decode helper for "core is out of reset" states.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RST_HOLD = 3'd1,
        RUN      = 3'd2,
        DRAIN    = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [31:0] PASS_CODE = 32'h0000_0001;

    // The core sees reset released from the first RUN cycle until the next
    // start/abort, so DONE keeps architectural state visible for inspection.
    function automatic logic core_released(input state_t s);
        return (s == RUN) || (s == DRAIN) || (s == DONE);
    endfunction

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and increment-by-N.
// Latency: 1 cycle from en/inc to cnt.
// Backpressure: none; sticks at all-ones instead of wrapping.
//
// Ports: clk, rst_n (async active-low), clr (sync clear, wins over en),
//        en (apply increment), inc[INC_W] (increment amount), cnt[W] (value).
module sat_counter #(
    parameter int W     = 32,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     cnt
);

    // One spare bit above the wider operand so the carry out is never lost.
    localparam int SUM_W = ((W > INC_W) ? W : INC_W) + 1;

    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] max_v;

    assign sum   = SUM_W'(cnt) + SUM_W'(inc);
    assign max_v = SUM_W'({W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (sum > max_v) ? {W{1'b1}} : sum[W-1:0];
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: sequences core reset, run, drain and completion status.
// Latency: all outputs registered; state/status update 1 cycle after inputs.
// Backpressure: none; start is ignored while a run is in flight, abort wins.
//
// Ports: clk, reset (async active-low), start, abort, halt_i, halt_code_i[32],
//        retire_i[NUM_RET] -> core_rst_n_o, run_o, done_o, timeout_o, pass_o,
//        cycle_cnt_o[CNT_W], ret_cnt_o[CNT_W], halt_code_o[32].
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int NUM_RET      = 1,
    parameter int RST_CYCLES   = 4,
    parameter int MAX_CYCLES   = 100,
    parameter int DRAIN_CYCLES = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               halt_i,
    input  logic [31:0]        halt_code_i,
    input  logic [NUM_RET-1:0] retire_i,
    output logic               core_rst_n_o,
    output logic               run_o,
    output logic               done_o,
    output logic               timeout_o,
    output logic               pass_o,
    output logic [CNT_W-1:0]   cycle_cnt_o,
    output logic [CNT_W-1:0]   ret_cnt_o,
    output logic [31:0]        halt_code_o
);

    localparam int RET_W  = $clog2(NUM_RET + 1);
    localparam int PH_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    // Terminal values of the shared phase counter and of the cycle budget.
    localparam logic [PH_W-1:0]  RST_LAST   = PH_W'((RST_CYCLES > 0) ? RST_CYCLES - 1 : 0);
    localparam logic [PH_W-1:0]  DRAIN_LAST = PH_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CYC_LAST   = CNT_W'(MAX_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [PH_W-1:0]  ph_cnt;
    logic [PH_W-1:0]  ph_nxt;
    logic             clr_cnt;
    logic             cyc_en;
    logic             ret_en;
    logic             timeout_nxt;
    logic [31:0]      code_nxt;
    logic [RET_W-1:0] ret_pop;

    always_comb begin
        ret_pop = '0;
        for (int i = 0; i < NUM_RET; i++) begin
            ret_pop = ret_pop + RET_W'(retire_i[i]);
        end
    end

    // Next-state and datapath controls. ph_cnt is shared: RST_HOLD and
    // DRAIN never overlap, so one counter times both phases.
    always_comb begin
        state_nxt   = state;
        ph_nxt      = ph_cnt;
        clr_cnt     = 1'b0;
        cyc_en      = 1'b0;
        ret_en      = 1'b0;
        timeout_nxt = timeout_o;
        code_nxt    = halt_code_o;

        if (abort) begin
            // Counters, timeout and halt code stay as they were for debug.
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        clr_cnt     = 1'b1;
                        timeout_nxt = 1'b0;
                        code_nxt    = '0;
                        ph_nxt      = '0;
                        state_nxt   = (RST_CYCLES == 0) ? RUN : RST_HOLD;
                    end
                end
                RST_HOLD: begin
                    if (ph_cnt == RST_LAST) begin
                        ph_nxt    = '0;
                        state_nxt = RUN;
                    end else begin
                        ph_nxt = ph_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (halt_i) begin
                        // The halting cycle is still a run cycle; the cycle
                        // counter stops after it. Halt beats the budget check.
                        cyc_en    = 1'b1;
                        ret_en    = 1'b1;
                        code_nxt  = halt_code_i;
                        ph_nxt    = '0;
                        state_nxt = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                    end else if (cycle_cnt_o == CYC_LAST) begin
                        timeout_nxt = 1'b1;
                        state_nxt   = DONE;
                    end else begin
                        cyc_en = 1'b1;
                        ret_en = 1'b1;
                    end
                end
                DRAIN: begin
                    ret_en = 1'b1;
                    if (ph_cnt == DRAIN_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        ph_nxt = ph_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they flop alongside it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ph_cnt       <= '0;
            core_rst_n_o <= 1'b0;
            run_o        <= 1'b0;
            done_o       <= 1'b0;
            timeout_o    <= 1'b0;
            pass_o       <= 1'b0;
            halt_code_o  <= '0;
        end else begin
            state        <= state_nxt;
            ph_cnt       <= ph_nxt;
            core_rst_n_o <= core_released(state_nxt);
            run_o        <= (state_nxt == RUN) || (state_nxt == DRAIN);
            done_o       <= (state_nxt == DONE);
            timeout_o    <= timeout_nxt;
            pass_o       <= (state_nxt == DONE) && (code_nxt == PASS_CODE) && !timeout_nxt;
            halt_code_o  <= code_nxt;
        end
    end

    sat_counter #(
        .W     (CNT_W),
        .INC_W (1)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr   (clr_cnt),
        .en    (cyc_en),
        .inc   (1'b1),
        .cnt   (cycle_cnt_o)
    );

    sat_counter #(
        .W     (CNT_W),
        .INC_W (RET_W)
    ) u_ret_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr   (clr_cnt),
        .en    (ret_en),
        .inc   (ret_pop),
        .cnt   (ret_cnt_o)
    );

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with a scoreboard of expected end-of-run status.
// Instance a: default parameters. Instance b: CNT_W=4, NUM_RET=2, MAX_CYCLES=11.
module tb_run_ctrl;
    import run_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Instance a
    logic        start_a, abort_a, halt_a;
    logic [31:0] code_in_a;
    logic [0:0]  retire_a;
    logic        core_rst_n_a, run_a, done_a, timeout_a, pass_a;
    logic [31:0] cyc_a, ret_a, code_a;

    // Instance b
    logic        start_b, abort_b, halt_b;
    logic [31:0] code_in_b;
    logic [1:0]  retire_b;
    logic        core_rst_n_b, run_b, done_b, timeout_b, pass_b;
    logic [3:0]  cyc_b, ret_b;
    logic [31:0] code_b;

    run_ctrl dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
        .halt_i(halt_a), .halt_code_i(code_in_a), .retire_i(retire_a),
        .core_rst_n_o(core_rst_n_a), .run_o(run_a), .done_o(done_a),
        .timeout_o(timeout_a), .pass_o(pass_a), .cycle_cnt_o(cyc_a),
        .ret_cnt_o(ret_a), .halt_code_o(code_a)
    );

    run_ctrl #(.CNT_W(4), .NUM_RET(2), .MAX_CYCLES(11)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
        .halt_i(halt_b), .halt_code_i(code_in_b), .retire_i(retire_b),
        .core_rst_n_o(core_rst_n_b), .run_o(run_b), .done_o(done_b),
        .timeout_o(timeout_b), .pass_o(pass_b), .cycle_cnt_o(cyc_b),
        .ret_cnt_o(ret_b), .halt_code_o(code_b)
    );

    typedef struct {
        longint      cyc;
        longint      ret;
        logic        to;
        logic        pass;
        logic [31:0] code;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input longint cyc, input longint ret, input logic to,
                            input logic pass, input logic [31:0] code);
        exp_t e;
        e.cyc = cyc; e.ret = ret; e.to = to; e.pass = pass; e.code = code;
        exp_q.push_back(e);
    endtask

    // Bounded wait for instance a's cycle counter to reach a value.
    task automatic wait_cyc_a(input string tag, input int target);
        int k = 0;
        while (cyc_a !== 32'(target) && k < 500) begin
            @(negedge clk);
            k++;
        end
        check(tag, 64'(cyc_a), 64'(target));
    endtask

    // Wait for done_o on instance a, then pop and compare the expected record.
    task automatic score_a(input string tag);
        int   k = 0;
        exp_t e;
        while (done_a !== 1'b1 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, 64'(done_a), 64'd1);
        check({tag, "_qnonempty"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_cycle"},   64'(cyc_a),     64'(e.cyc));
            check({tag, "_ret"},     64'(ret_a),     64'(e.ret));
            check({tag, "_timeout"}, 64'(timeout_a), 64'(e.to));
            check({tag, "_pass"},    64'(pass_a),    64'(e.pass));
            check({tag, "_code"},    64'(code_a),    64'(e.code));
        end
        check({tag, "_run_low"},  64'(run_a),        64'd0);
        check({tag, "_core_out"}, 64'(core_rst_n_a), 64'd1);
    endtask

    task automatic score_b(input string tag);
        int   k = 0;
        exp_t e;
        while (done_b !== 1'b1 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, 64'(done_b), 64'd1);
        check({tag, "_qnonempty"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_cycle"},   64'(cyc_b),     64'(e.cyc));
            check({tag, "_ret"},     64'(ret_b),     64'(e.ret));
            check({tag, "_timeout"}, 64'(timeout_b), 64'(e.to));
            check({tag, "_pass"},    64'(pass_b),    64'(e.pass));
            check({tag, "_code"},    64'(code_b),    64'(e.code));
        end
    endtask

    // Core reset must stay low for 4 samples after the start edge, then rise.
    task automatic check_hold_a(input string tag);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_rst_low"}, 64'(core_rst_n_a), 64'd0);
            @(negedge clk);
        end
        check({tag, "_rst_high"}, 64'(core_rst_n_a), 64'd1);
        check({tag, "_run_high"}, 64'(run_a), 64'd1);
        check({tag, "_cyc0"}, 64'(cyc_a), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        reset = 1'b0;
        start_a = 0; abort_a = 0; halt_a = 0; code_in_a = '0; retire_a = '0;
        start_b = 0; abort_b = 0; halt_b = 0; code_in_b = '0; retire_b = '0;

        // Reset, then idle with no start: nothing may begin.
        repeat (3) @(negedge clk);
        check("in_reset_rst_n", 64'(core_rst_n_a), 64'd0);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_state", 64'(dut_a.state), 64'(IDLE));
        check("idle_rst_n", 64'(core_rst_n_a), 64'd0);
        check("idle_run",   64'(run_a), 64'd0);
        check("idle_cyc",   64'(cyc_a), 64'd0);
        check("idle_ret",   64'(ret_a), 64'd0);
        check("idle_done",  64'(done_a), 64'd0);

        // Run 1: halt with PASS code on the 20th run cycle, retire every cycle.
        start_a = 1; retire_a = 1'b1;
        @(negedge clk);
        start_a = 0;
        check_hold_a("r1");
        wait_cyc_a("r1_reach19", 19);
        halt_a = 1; code_in_a = 32'd1;
        push_exp(20, 25, 1'b0, 1'b1, 32'd1);
        @(negedge clk);
        // Halt in DRAIN with a different code must be ignored.
        code_in_a = 32'd9;
        d = 0;
        while (done_a !== 1'b1 && d < 20) begin
            if (run_a === 1'b1) d++;
            @(negedge clk);
        end
        halt_a = 0; code_in_a = '0;
        check("r1_drain_len", 64'(d), 64'd5);
        score_a("r1");

        // Run 2: restart from DONE, never halt -> budget timeout.
        retire_a = 1'b0;
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        check("r2_clr_cyc",  64'(cyc_a), 64'd0);
        check("r2_clr_done", 64'(done_a), 64'd0);
        check("r2_clr_pass", 64'(pass_a), 64'd0);
        check("r2_clr_code", 64'(code_a), 64'd0);
        check("r2_rst_n",    64'(core_rst_n_a), 64'd0);
        push_exp(99, 0, 1'b1, 1'b0, 32'd0);
        score_a("r2");

        // Run 3: halt on the budget cycle with a failing code.
        start_a = 1; retire_a = 1'b1;
        @(negedge clk);
        start_a = 0;
        check("r3_clr_timeout", 64'(timeout_a), 64'd0);
        wait_cyc_a("r3_reach99", 99);
        halt_a = 1; code_in_a = 32'd7;
        push_exp(100, 105, 1'b0, 1'b0, 32'd7);
        @(negedge clk);
        halt_a = 0; code_in_a = '0;
        check("r3_drain_run", 64'(run_a), 64'd1);
        check("r3_drain_to",  64'(timeout_a), 64'd0);
        check("r3_drain_state", 64'(dut_a.state), 64'(DRAIN));
        score_a("r3");

        // Run 4: abort mid-RUN together with start; abort wins.
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        wait_cyc_a("r4_reach30", 30);
        abort_a = 1; start_a = 1; halt_a = 1; code_in_a = 32'd1;
        @(negedge clk);
        abort_a = 0; halt_a = 0; code_in_a = '0;
        check("ab_state", 64'(dut_a.state), 64'(IDLE));
        check("ab_rst_n", 64'(core_rst_n_a), 64'd0);
        check("ab_run",   64'(run_a), 64'd0);
        check("ab_done",  64'(done_a), 64'd0);
        check("ab_cyc",   64'(cyc_a), 64'd30);
        check("ab_ret",   64'(ret_a), 64'd30);
        check("ab_code",  64'(code_a), 64'd0);
        @(negedge clk);
        start_a = 0;
        check("ab_new_cyc", 64'(cyc_a), 64'd0);
        check("ab_new_ret", 64'(ret_a), 64'd0);
        check_hold_a("ab");

        // Asynchronous reset mid-run clears everything without a clock edge.
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_state", 64'(dut_a.state), 64'(IDLE));
        check("arst_rst_n", 64'(core_rst_n_a), 64'd0);
        check("arst_run",   64'(run_a), 64'd0);
        check("arst_cyc",   64'(cyc_a), 64'd0);
        check("arst_ret",   64'(ret_a), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        retire_a = 1'b0;
        repeat (3) @(negedge clk);
        check("arst_no_autostart", 64'(core_rst_n_a), 64'd0);

        // Instance b: two retires per cycle into a 4-bit counter saturates at 15.
        start_b = 1; retire_b = 2'b11;
        @(negedge clk);
        start_b = 0;
        push_exp(10, 15, 1'b1, 1'b0, 32'd0);
        score_b("sat");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of cycle and retire counters.
REQ-002 SHALL have parameter NUM_RET, default 1, number of retire channels summed per cycle.
REQ-003 SHALL have parameter RST_CYCLES, default 4, cycles the core is held in reset after start.
REQ-004 SHALL have parameter MAX_CYCLES, default 100, run-cycle budget before timeout.
REQ-005 SHALL have parameter DRAIN_CYCLES, default 5, post-halt pipeline drain cycles.
REQ-006 SHALL have port clk  in  1  single clock, rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port start  in  1  begin (or restart) a run; sampled each cycle.
REQ-009 SHALL have port abort  in  1  terminate the run and return to idle.
REQ-010 SHALL have port halt_i  in  1  core halt indication (ecall/tohost write).
REQ-011 SHALL have port halt_code_i  in  32  value qualifying halt_i.
REQ-012 SHALL have port retire_i  in  NUM_RET  one bit per instruction retired this cycle.
REQ-013 SHALL have port core_rst_n_o  out  1  active-low reset driven to main_pipe.
REQ-014 SHALL have port run_o  out  1  core is executing (RUN or DRAIN).
REQ-015 SHALL have port done_o  out  1  run complete; status valid.
REQ-016 SHALL have port timeout_o  out  1  run ended by cycle budget.
REQ-017 SHALL have port pass_o  out  1  halted with PASS_CODE and no timeout.
REQ-018 SHALL have ports cycle_cnt_o, ret_cnt_o  out  CNT_W  run cycles, retired instructions; halt_code_o  out  32  latched halt code.

Function
REQ-019 SHALL implement states IDLE, RST_HOLD, RUN, DRAIN, DONE; all outputs registered.
REQ-020 IDLE: core_rst_n_o=0, run_o=0; start=1 -> RST_HOLD next cycle, clearing counters, halt_code_o, done_o, timeout_o, pass_o.
REQ-021 RST_HOLD: core_rst_n_o=0 for exactly RST_CYCLES cycles, then RUN; RST_CYCLES=0 goes directly to RUN.
REQ-022 RUN: core_rst_n_o=1, run_o=1; cycle_cnt_o +1 per cycle; ret_cnt_o += popcount(retire_i).
REQ-023 Both counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-024 RUN with halt_i=1 -> latch halt_code_i, DRAIN; cycle_cnt_o freezes at its value that cycle.
REQ-025 RUN with cycle_cnt_o==MAX_CYCLES-1 and halt_i=0 -> timeout_o=1, DONE; halt_i in the same cycle wins over timeout.
REQ-026 DRAIN: run_o=1, retires still counted, halt_i ignored; after DRAIN_CYCLES cycles -> DONE.
REQ-027 DONE: done_o=1, run_o=0, core_rst_n_o=1 (state preserved for inspection); pass_o=(halt_code_o==PASS_CODE)&&!timeout_o.
REQ-028 start SHALL be ignored in RST_HOLD, RUN, DRAIN; start in DONE behaves as in IDLE (restart).
REQ-029 abort=1 in any state -> IDLE next cycle, core_rst_n_o=0, counters preserved, done_o=0; abort has priority over start, halt_i and timeout.

Reset
REQ-030 reset=0 SHALL asynchronously force IDLE, core_rst_n_o=0, run_o=0, all status and counters 0.
REQ-031 reset deassertion alone SHALL NOT start a run; a start pulse is required.

Structure
REQ-032 Package run_ctrl_pkg SHALL hold the state enum and PASS_CODE constant (32'h0000_0001).
REQ-033 One sub-module sat_counter (width-parametrised, saturating, increment-by-N input) SHALL implement both counters.

Verification
REQ-034 reset low, release, no start for 10 cycles -> state IDLE, core_rst_n_o=0, all counters 0.
REQ-035 start at cycle 0, RST_CYCLES=4, halt_i with code 1 at run cycle 20, retire_i=1 every run cycle -> core_rst_n_o rises after 4 cycles; cycle_cnt_o=20; ret_cnt_o=25; done_o after 5 drain cycles; pass_o=1.
REQ-036 start, halt never asserted, MAX_CYCLES=100 -> timeout_o=1, done_o=1, cycle_cnt_o=99, pass_o=0.
REQ-037 halt_i asserted on the budget cycle (cycle_cnt_o=99) -> DRAIN entered, timeout_o=0; halt code 7 -> pass_o=0.
REQ-038 NUM_RET=2, retire_i=2'b11 for 10 cycles, CNT_W=4 -> ret_cnt_o saturates at 15.
REQ-039 abort mid-RUN at cycle 30, then start -> core_rst_n_o=0 next cycle, new run clears counters, RST_HOLD repeats 4 cycles.
